// File: rtl/conv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_pkg - shared state type and window-position helpers, rev 1.0
// ----------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int window_count(input int w, input int h, input int n, input int s);
    return ((w - n) / s + 1) * ((h - n) / s + 1);
  endfunction

  function automatic logic emit_pos(input int r, input int c, input int n, input int s);
    return (r >= n - 1) && (c >= n - 1) &&
           ((r - (n - 1)) % s == 0) && ((c - (n - 1)) % s == 0);
  endfunction

  // Coordinate of the last stride-aligned window corner along one axis.
  function automatic int last_pos(input int len, input int n, input int s);
    return (n - 1) + ((len - n) / s) * s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_line_buffer - last N-1 image rows of full pixels, addressed by column, rev 1.0
// ----------------------------------------------------------------------------
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int N          = 3,
  parameter int ImageWidth = 4,
  parameter int PixBits    = 4,
  localparam int ColBits   = $clog2(ImageWidth)
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [ColBits-1:0]        col,
  input  logic [PixBits-1:0]        wr_pix,
  output logic [(N-1)*PixBits-1:0]  rd_pix
);

  // Row 0 is the oldest stored row, row N-2 the most recent one.
  logic [PixBits-1:0] mem [N-1][ImageWidth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < N - 2; k++) begin
        mem[k][col] <= mem[k+1][col];
      end
      mem[N-2][col] <= wr_pix;
    end
  end

  for (genvar k = 0; k < N - 1; k++) begin : g_rd
    assign rd_pix[k*PixBits +: PixBits] = mem[k][col];
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_window_buffer - streaming N x N x Channels window generator with handshakes, rev 1.0
// ----------------------------------------------------------------------------
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int N           = 3,
  parameter int BitSize     = 4,
  parameter int Channels    = 1,
  parameter int ImageWidth  = 4,
  parameter int ImageHeight = 4,
  parameter int Stride      = 1
) (
  input  logic                               clk,
  input  logic                               res_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [Channels*BitSize-1:0]        in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N*N*Channels*BitSize-1:0]    out_data,
  output logic                               out_done
);

  localparam int PixBits = Channels * BitSize;
  localparam int WinBits = N * N * PixBits;
  localparam int ColBits = $clog2(ImageWidth);
  localparam int RowBits = $clog2(ImageHeight);
  localparam int LastR   = last_pos(ImageHeight, N, Stride);
  localparam int LastC   = last_pos(ImageWidth, N, Stride);

  state_e               state, state_next;
  logic [ColBits-1:0]   col;
  logic [RowBits-1:0]   row;
  logic                 accept, col_last, row_last, frame_end, emit, emit_last;
  logic [(N-1)*PixBits-1:0] line_pix;
  logic [N*PixBits-1:0] col_pix;
  logic [WinBits-1:0]   win, win_next;

  assign in_ready  = res_n && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign col_last  = (col == ColBits'(ImageWidth - 1));
  assign row_last  = (row == RowBits'(ImageHeight - 1));
  assign frame_end = col_last && row_last;
  assign emit      = (state == RUN) && emit_pos(int'(row), int'(col), N, Stride);
  assign emit_last = emit && (row == RowBits'(LastR)) && (col == ColBits'(LastC));
  assign col_pix   = {in_data, line_pix};

  conv_line_buffer #(
    .N          (N),
    .ImageWidth (ImageWidth),
    .PixBits    (PixBits)
  ) u_lines (
    .clk    (clk),
    .wr_en  (accept),
    .col    (col),
    .wr_pix (in_data),
    .rd_pix (line_pix)
  );

  // Shift every window row left by one pixel and append the new column on the right.
  always_comb begin
    win_next = win;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N - 1; j++) begin
        win_next[(i*N+j)*PixBits +: PixBits] = win[(i*N+j+1)*PixBits +: PixBits];
      end
      win_next[(i*N+N-1)*PixBits +: PixBits] = col_pix[i*PixBits +: PixBits];
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        FILL: if (col_last && row == RowBits'(N - 2)) state_next = RUN;
        RUN:  if (frame_end) state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) win <= win_next;
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state     <= FILL;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_done  <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
      end
      if (accept && emit) begin
        out_valid <= 1'b1;
        out_data  <= win_next;
        out_done  <= emit_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_done  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv_window_buffer - table vectors, directed corner cases and random frames vs a frame model, rev 1.0
// ----------------------------------------------------------------------------
module tb_conv_window_buffer;

  typedef struct {
    logic [127:0] data;
    bit           done;
  } win_t;

  typedef struct {
    int pix;
    bit exp_valid;
    bit exp_done;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_res_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_done;
  logic [3:0]  a_in_data;
  logic [35:0] a_out_data;
  logic        b_res_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_done;
  logic [7:0]  b_in_data;
  logic [71:0] b_out_data;

  conv_window_buffer dut_a (
    .clk(clk), .res_n(a_res_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_done(a_out_done)
  );

  conv_window_buffer #(
    .N(3), .BitSize(4), .Channels(2), .ImageWidth(5), .ImageHeight(5), .Stride(2)
  ) dut_b (
    .clk(clk), .res_n(b_res_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_done(b_out_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  win_t qa[$];
  win_t qb[$];
  int a_wins = 0, a_dones = 0, b_wins = 0, b_dones = 0;
  logic [127:0] b_first = '0;
  bit b_first_seen = 1'b0;

  int basic[$]   = '{7, 2, 2, 15, 8, 8, 15, 7, 15, 2, 8, 8, 15, 8, 8, 8};
  int first_w[9] = '{7, 2, 2, 8, 8, 15, 15, 2, 8};
  int last_w[9]  = '{8, 15, 7, 2, 8, 8, 8, 8, 8};
  int first_b[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk3(input int v[9]);
    logic [127:0] r = '0;
    for (int k = 0; k < 9; k++) r[k*4 +: 4] = 4'(v[k]);
    return r;
  endfunction

  // Frame-level model: enumerate every stride-aligned 3x3 window of the image.
  function automatic void model(input bit sel, input int w, input int h, input int s,
                                input int ch, input int pix[$]);
    win_t e;
    for (int r = 2; r < h; r += s) begin
      for (int c = 2; c < w; c += s) begin
        e.data = '0;
        e.done = (r + s >= h) && (c + s >= w);
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            for (int k = 0; k < ch; k++)
              e.data[((wr*3+wc)*ch+k)*4 +: 4] = 4'(pix[((r-2+wr)*w + (c-2+wc))*ch + k]);
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
      end
    end
  endfunction

  always @(negedge clk) begin
    win_t e;
    if (a_res_n && a_out_valid && a_out_ready) begin
      a_wins++;
      if (a_out_done) a_dones++;
      if (qa.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_window: got %0h expected none", a_out_data);
      end else begin
        e = qa.pop_front();
        check("a_window", {91'b0, a_out_done, a_out_data}, {91'b0, e.done, e.data[35:0]});
      end
    end
  end

  always @(negedge clk) begin
    win_t e;
    logic [127:0] c1, c0p1;
    if (b_res_n && b_out_valid && b_out_ready) begin
      b_wins++;
      if (b_out_done) b_dones++;
      if (!b_first_seen) begin
        b_first = {56'b0, b_out_data};
        b_first_seen = 1'b1;
      end
      c1 = '0;
      c0p1 = '0;
      for (int p = 0; p < 9; p++) begin
        c1[p*4 +: 4]   = b_out_data[p*8+4 +: 4];
        c0p1[p*4 +: 4] = b_out_data[p*8 +: 4] + 4'd1;
      end
      check("b_ch1_is_ch0_plus1", c1, c0p1);
      if (qb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected_window: got %0h expected none", b_out_data);
      end else begin
        e = qb.pop_front();
        check("b_window", {55'b0, b_out_done, b_out_data}, {55'b0, e.done, e.data[71:0]});
      end
    end
  end

  task automatic send_a(input int pix[$], input int bubble_pct, input int stall_pct);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < pix.size()) begin
      a_in_valid  = ($urandom_range(99) >= bubble_pct);
      a_in_data   = 4'(pix[i]);
      a_out_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
      if (guard > 5000) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_send_timeout: got %0d accepted expected %0d", i, pix.size());
        break;
      end
    end
  endtask

  task automatic send_b(input int pix[$], input int bubble_pct, input int stall_pct);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < pix.size()) begin
      b_in_valid  = ($urandom_range(99) >= bubble_pct);
      b_in_data   = 8'(pix[i]);
      b_out_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      acc = b_in_valid && b_in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
      if (guard > 5000) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_send_timeout: got %0d accepted expected %0d", i, pix.size());
        break;
      end
    end
  endtask

  task automatic drain_a();
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    logic [35:0] saved;
    logic [127:0] got;
    int wins0, dones0, v;
    int rnd[$];
    int bpix[$];
    int bflat[$];
    time t0;

    for (int i = 0; i < 16; i++) begin
      tbl[i].pix       = basic[i];
      tbl[i].exp_valid = (i == 10) || (i == 11) || (i == 14) || (i == 15);
      tbl[i].exp_done  = (i == 15);
    end

    a_res_n = 1'b0; b_res_n = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_in_data = '0; b_in_data = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_in_ready", 128'(a_in_ready), 128'(0));
    check("rst_a_out_valid", 128'(a_out_valid), 128'(0));
    check("rst_a_out_done", 128'(a_out_done), 128'(0));
    check("rst_a_out_data", 128'(a_out_data), 128'(0));
    check("rst_b_in_ready", 128'(b_in_ready), 128'(0));
    check("rst_b_out_valid", 128'(b_out_valid), 128'(0));
    @(posedge clk);
    #1;
    a_res_n = 1'b1;
    b_res_n = 1'b1;

    // Basic stream from the vector table
    model(1'b0, 4, 4, 1, 1, basic);
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 4'(tbl[i].pix);
      @(posedge clk);
      #1;
      check("tbl_valid", 128'(a_out_valid), 128'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check("tbl_done", 128'(a_out_done), 128'(tbl[i].exp_done));
      if (i == 10) check("first_window", 128'(a_out_data), mk3(first_w));
      if (i == 15) check("last_window", 128'(a_out_data), mk3(last_w));
    end
    drain_a();
    check("tbl_count", 128'(a_wins), 128'(4));

    // Backpressure: hold the first window for three cycles
    wins0 = a_wins;
    model(1'b0, 4, 4, 1, 1, basic);
    a_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_in_data = 4'(basic[i]);
      if (i == 11) begin
        a_out_ready = 1'b0;
        saved = a_out_data;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_in_ready", 128'(a_in_ready), 128'(0));
          check("bp_out_valid", 128'(a_out_valid), 128'(1));
          check("bp_data_stable", 128'(a_out_data), 128'(saved));
          @(posedge clk);
          #1;
        end
        a_out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    drain_a();
    check("bp_count", 128'(a_wins - wins0), 128'(4));

    // Back-to-back frames at full rate
    wins0 = a_wins;
    dones0 = a_dones;
    rnd = {};
    for (int i = 0; i < 16; i++) rnd.push_back(int'($urandom_range(15)));
    model(1'b0, 4, 4, 1, 1, basic);
    model(1'b0, 4, 4, 1, 1, rnd);
    t0 = $time;
    send_a(basic, 0, 0);
    send_a(rnd, 0, 0);
    check("b2b_cycles", 128'(($time - t0) / 10), 128'(32));
    drain_a();
    check("b2b_count", 128'(a_wins - wins0), 128'(8));
    check("b2b_dones", 128'(a_dones - dones0), 128'(2));

    // Reset after the ninth pixel of a frame
    model(1'b0, 4, 4, 1, 1, basic);
    a_in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_in_data = 4'(basic[i]);
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    a_res_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 128'(a_in_ready), 128'(0));
    check("midrst_out_valid", 128'(a_out_valid), 128'(0));
    @(posedge clk);
    #1;
    a_res_n = 1'b1;
    qa.delete();
    wins0 = a_wins;
    model(1'b0, 4, 4, 1, 1, basic);
    send_a(basic, 0, 0);
    drain_a();
    check("midrst_count", 128'(a_wins - wins0), 128'(4));

    // Random frames with bubbles and stalls
    for (int f = 0; f < 4; f++) begin
      rnd = {};
      for (int i = 0; i < 16; i++) rnd.push_back(int'($urandom_range(15)));
      model(1'b0, 4, 4, 1, 1, rnd);
      send_a(rnd, 30, 30);
    end
    drain_a();
    check("a_queue_empty", 128'(qa.size()), 128'(0));

    // Stride 2, two channels: indexed frame then random frames
    bpix = {};
    bflat = {};
    for (int i = 0; i < 25; i++) begin
      v = i % 16;
      bpix.push_back(v | (((v + 1) % 16) << 4));
      bflat.push_back(v);
      bflat.push_back((v + 1) % 16);
    end
    model(1'b1, 5, 5, 2, 2, bflat);
    send_b(bpix, 0, 0);
    drain_b();
    check("b_count", 128'(b_wins), 128'(4));
    check("b_dones", 128'(b_dones), 128'(1));
    got = '0;
    for (int p = 0; p < 9; p++) got[p*4 +: 4] = b_first[p*8 +: 4];
    check("b_first_window", got, mk3(first_b));

    for (int f = 0; f < 3; f++) begin
      bpix = {};
      bflat = {};
      for (int i = 0; i < 25; i++) begin
        v = int'($urandom_range(15));
        bpix.push_back(v | (((v + 1) % 16) << 4));
        bflat.push_back(v);
        bflat.push_back((v + 1) % 16);
      end
      model(1'b1, 5, 5, 2, 2, bflat);
      send_b(bpix, 25, 35);
    end
    drain_b();
    check("b_total_count", 128'(b_wins), 128'(16));
    check("b_queue_empty", 128'(qb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
